// File: rtl/dcache_write_buffer.sv
// Line-granular posted write buffer between the D-cache memory port and slow data memory.
// Write-backs are acked in one cycle and drained in the background; reads forward from
// the buffer (youngest match) or go to memory ahead of pending drains.
module dcache_write_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cache_read,
  input  logic              cache_write,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic [LINE_W-1:0] cache_wdata,
  output logic [LINE_W-1:0] cache_rdata,
  output logic              cache_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              wb_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count, count_n;
  logic              rd_pend;

  logic              sample, wr_acc, rd_req, rd_hit, rd_miss, push, pop, head_busy;
  logic              hit, co_hit;
  logic [PTR_W-1:0]  hit_idx, co_idx;

  // Physical slot holding the k-th oldest entry.
  function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] h, input int k);
    return h + PTR_W'(k);
  endfunction

  // New requests are only looked at when nothing is being served or acked.
  assign sample    = !cache_ready && !rd_pend;
  assign wr_acc    = sample && cache_write && (count < CNT_W'(DEPTH));
  assign rd_req    = sample && cache_read && !cache_write;
  assign rd_hit    = rd_req && hit;
  assign rd_miss   = rd_req && !hit;
  assign push      = wr_acc && !co_hit;
  assign pop       = (state == S_WR) && mem_ready;
  assign head_busy = (state == S_WR) || (state_n == S_WR);
  assign count_n   = count + CNT_W'(push) - CNT_W'(pop);

  // Read forwarding: youngest valid entry matching the request address.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if ((CNT_W'(k) < count) && (addr_q[slot(head, k)] == cache_addr)) begin
        hit     = 1'b1;
        hit_idx = slot(head, k);
      end
    end
  end

  // Coalesce target: matching entry other than a head that is (or is about to be) draining.
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if ((CNT_W'(k) < count) && (addr_q[slot(head, k)] == cache_addr) &&
          !((k == 0) && head_busy)) begin
        co_hit = 1'b1;
        co_idx = slot(head, k);
      end
    end
  end

  // Memory FSM next state: read misses beat drains, transactions run to mem_ready.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (rd_pend || rd_miss)  state_n = S_RD;
        else if (count != '0)    state_n = S_WR;
      end
      S_RD:    if (mem_ready) state_n = S_IDLE;
      S_WR:    if (mem_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Line storage: push at tail or overwrite a coalesce target in place.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= cache_addr;
      data_q[tail] <= cache_wdata;
    end else if (wr_acc && co_hit) begin
      data_q[co_idx] <= cache_wdata;
    end
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      rd_pend     <= 1'b0;
      cache_ready <= 1'b0;
      cache_rdata <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wb_empty    <= 1'b1;
    end else begin
      state       <= state_n;
      count       <= count_n;
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);

      if (rd_miss)                         rd_pend <= 1'b1;
      else if ((state == S_RD) && mem_ready) rd_pend <= 1'b0;

      cache_ready <= wr_acc || rd_hit || ((state == S_RD) && mem_ready);
      if (rd_hit)                            cache_rdata <= data_q[hit_idx];
      else if ((state == S_RD) && mem_ready) cache_rdata <= mem_rdata;

      mem_read  <= (state_n == S_RD);
      mem_write <= (state_n == S_WR);
      if ((state == S_IDLE) && (state_n == S_WR)) begin
        mem_addr  <= addr_q[head];
        mem_wdata <= data_q[head];
      end else if ((state == S_IDLE) && (state_n == S_RD)) begin
        mem_addr  <= cache_addr;
      end

      wb_empty <= (count_n == '0) && (state_n != S_WR);
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Self-checking bench for dcache_write_buffer: directed sequences, a vector table and
// randomized traffic checked against a last-write-wins memory model.
module tb_dcache_write_buffer;

  logic         clk, rst_n;
  logic         cache_read, cache_write;
  logic [27:0]  cache_addr;
  logic [127:0] cache_wdata, cache_rdata;
  logic         cache_ready;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;
  logic         wb_empty;

  dcache_write_buffer #(.DEPTH(4), .ADDR_W(28), .LINE_W(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .cache_read(cache_read), .cache_write(cache_write), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_ready(cache_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wb_empty(wb_empty)
  );

  typedef struct { bit wr; logic [27:0] a; logic [127:0] d; } op_t;
  typedef struct { bit wr; logic [27:0] addr; logic [127:0] data; logic [127:0] exp; } vec_t;

  int  checks = 0;
  int  errors = 0;
  int  pcyc = 0;
  int  last_ready_cyc = 0;
  int  ack_cyc = 0;
  int  both_cnt = 0;
  int  unstable = 0;
  int  wr_cycles = 0;
  bit  auto_mem = 0;
  bit  man_go = 0;
  op_t oplog[$];
  logic [127:0] memv [logic [27:0]];
  logic [127:0] golden [logic [27:0]];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) pcyc <= pcyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [127:0] init_line(input logic [27:0] a);
    return {4{4'hA, a}};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Slow memory model: sole driver of mem_ready/mem_rdata, logs every completed transfer.
  initial begin : mem_model
    int lat_cnt, lat;
    bit held;
    logic [27:0]  ha;
    logic [127:0] hd;
    mem_ready = 0; mem_rdata = '0;
    lat_cnt = 0; lat = 1; held = 0; ha = '0; hd = '0;
    forever begin
      @(negedge clk);
      if (mem_read && mem_write) both_cnt++;
      if (mem_write) wr_cycles++;
      if (mem_ready) begin
        mem_ready = 0;
      end else if (mem_read || mem_write) begin
        if (!held) begin
          held = 1; ha = mem_addr; hd = mem_wdata;
        end else if (mem_addr !== ha || (mem_write && mem_wdata !== hd)) begin
          unstable++;
        end
        if (auto_mem ? (lat_cnt >= lat) : man_go) begin
          if (mem_write) begin
            memv[mem_addr] = mem_wdata;
            oplog.push_back('{1'b1, mem_addr, mem_wdata});
          end else begin
            mem_rdata = memv.exists(mem_addr) ? memv[mem_addr] : init_line(mem_addr);
            oplog.push_back('{1'b0, mem_addr, '0});
          end
          mem_ready = 1;
          last_ready_cyc = pcyc;
          man_go = 0;
          lat_cnt = 0;
          lat = $urandom_range(0, 3);
          held = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        held = 0;
      end
    end
  end

  task automatic cache_req(input bit rd, input bit wr, input logic [27:0] a,
                           input logic [127:0] d, output logic [127:0] rdat,
                           output int lat, output bit acked);
    @(posedge clk); #1;
    cache_read = rd; cache_write = wr; cache_addr = a; cache_wdata = d;
    acked = 0; lat = 0; rdat = '0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (!rst_n) break;
      if (cache_ready) begin
        acked = 1; lat = i; rdat = cache_rdata; ack_cyc = pcyc;
        break;
      end
    end
    @(posedge clk); #1;
    cache_read = 0; cache_write = 0;
  endtask

  task automatic wait_for(input string nm, input int sel, input int bound);
    bit seen;
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      case (sel)
        0:       seen = wb_empty;
        1:       seen = mem_write;
        2:       seen = mem_read;
        default: seen = 0;
      endcase
      if (seen) break;
    end
    chk(nm, 128'(seen), 128'd1);
  endtask

  task automatic chk_op(input string nm, input int idx, input bit wr, input logic [27:0] a,
                        input logic [127:0] d);
    if (idx < oplog.size()) begin
      chk({nm, "_kind"}, 128'(oplog[idx].wr), 128'(wr));
      chk({nm, "_addr"}, 128'(oplog[idx].a), 128'(a));
      if (wr) chk({nm, "_data"}, oplog[idx].d, d);
    end else begin
      chk({nm, "_missing"}, 128'(oplog.size()), 128'(idx + 1));
    end
  endtask

  initial begin : stim
    vec_t         vecs[8];
    logic [127:0] rd, d, expd;
    logic [27:0]  a;
    int           lat, m, wc, ac;
    bit           ok, ok5, done5;

    rst_n = 0; cache_read = 0; cache_write = 0; cache_addr = '0; cache_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cache_ready", 128'(cache_ready), 0);
    chk("rst_mem_read",    128'(mem_read),    0);
    chk("rst_mem_write",   128'(mem_write),   0);
    chk("rst_mem_addr",    128'(mem_addr),    0);
    chk("rst_mem_wdata",   mem_wdata,         0);
    chk("rst_cache_rdata", cache_rdata,       0);
    chk("rst_wb_empty",    128'(wb_empty),    1);
    rst_n = 1;

    // Single posted write, drained under manual memory control.
    auto_mem = 0;
    d = {4{32'hD1D1_0001}};
    cache_req(0, 1, 28'h10, d, rd, lat, ok);
    chk("t1_ack", 128'(ok), 1);
    chk("t1_lat", 128'(lat), 2);
    chk("t1_wb_empty_busy", 128'(wb_empty), 0);
    wait_for("t1_mem_write_seen", 1, 20);
    chk("t1_mem_addr", 128'(mem_addr), 128'h10);
    chk("t1_mem_wdata", mem_wdata, d);
    man_go = 1;
    wait_for("t1_wb_empty_after", 0, 20);

    // Fill the buffer with the drain held off, then a fifth write must wait for a pop.
    m = oplog.size();
    for (int i = 0; i < 4; i++) begin
      cache_req(0, 1, 28'(28'h10 + i), {4{32'(32'hF00 + i)}}, rd, lat, ok);
      chk($sformatf("t2_fill%0d_lat", i), 128'(lat), 2);
    end
    done5 = 0;
    fork
      begin
        cache_req(0, 1, 28'h14, {4{32'hF04}}, rd, lat, ok5);
        done5 = 1;
      end
      begin
        repeat (6) @(negedge clk);
        chk("t2_stall_no_ack", 128'(done5), 0);
        man_go = 1;
      end
    join
    chk("t2_fifth_ack", 128'(ok5), 1);
    chk("t2_fifth_timing", 128'(ack_cyc - last_ready_cyc), 2);
    auto_mem = 1;
    wait_for("t2_drained", 0, 200);
    chk("t2_ops", 128'(oplog.size() - m), 5);
    for (int i = 0; i < 5; i++)
      chk_op($sformatf("t2_op%0d", i), m + i, 1, 28'(28'h10 + i), {4{32'(32'hF00 + i)}});

    // Coalescing behind a busy head, then forward the newest data.
    auto_mem = 0;
    m = oplog.size();
    cache_req(0, 1, 28'h1F, {4{32'h1F1F}}, rd, lat, ok);
    cache_req(0, 1, 28'h20, {4{32'hD1}}, rd, lat, ok);
    cache_req(0, 1, 28'h20, {4{32'hD2}}, rd, lat, ok);
    chk("t3_coalesce_lat", 128'(lat), 2);
    cache_req(1, 0, 28'h20, '0, rd, lat, ok);
    chk("t3_fwd_data", rd, {4{32'hD2}});
    chk("t3_fwd_lat", 128'(lat), 2);
    auto_mem = 1;
    wait_for("t3_drained", 0, 200);
    chk("t3_ops", 128'(oplog.size() - m), 2);
    chk_op("t3_op0", m, 1, 28'h1F, {4{32'h1F1F}});
    chk_op("t3_op1", m + 1, 1, 28'h20, {4{32'hD2}});

    // Read miss arriving mid-drain waits, then beats the remaining drain.
    auto_mem = 0;
    m = oplog.size();
    cache_req(0, 1, 28'h2F, {4{32'h2F2F}}, rd, lat, ok);
    cache_req(0, 1, 28'h30, {4{32'h3030}}, rd, lat, ok);
    fork
      cache_req(1, 0, 28'h40, '0, rd, lat, ok);
      begin
        repeat (5) @(negedge clk);
        chk("t4_no_read_mid_wr", 128'(mem_read), 0);
        chk("t4_wr_held", 128'(mem_write), 1);
        man_go = 1;
        auto_mem = 1;
      end
    join
    chk("t4_read_ack", 128'(ok), 1);
    chk("t4_read_data", rd, init_line(28'h40));
    wait_for("t4_drained", 0, 200);
    chk("t4_ops", 128'(oplog.size() - m), 3);
    chk_op("t4_op0", m, 1, 28'h2F, {4{32'h2F2F}});
    chk_op("t4_op1", m + 1, 0, 28'h40, '0);
    chk_op("t4_op2", m + 2, 1, 28'h30, {4{32'h3030}});

    // Vector table with random memory latency.
    vecs[0] = '{1'b1, 28'h100, {4{32'hA0A0_0100}}, '0};
    vecs[1] = '{1'b0, 28'h100, '0, {4{32'hA0A0_0100}}};
    vecs[2] = '{1'b0, 28'h101, '0, init_line(28'h101)};
    vecs[3] = '{1'b1, 28'h101, {4{32'hB1B1_0101}}, '0};
    vecs[4] = '{1'b1, 28'h100, {4{32'hC2C2_0100}}, '0};
    vecs[5] = '{1'b0, 28'h100, '0, {4{32'hC2C2_0100}}};
    vecs[6] = '{1'b0, 28'h101, '0, {4{32'hB1B1_0101}}};
    vecs[7] = '{1'b0, 28'h102, '0, init_line(28'h102)};
    foreach (vecs[i]) begin
      cache_req(!vecs[i].wr, vecs[i].wr, vecs[i].addr, vecs[i].data, rd, lat, ok);
      chk($sformatf("vec%0d_ack", i), 128'(ok), 1);
      if (vecs[i].wr) chk($sformatf("vec%0d_lat", i), 128'(lat), 2);
      else            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end

    // Randomized traffic against a last-write-wins model.
    for (int n = 0; n < 200; n++) begin
      a = 28'(28'h200 + $urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        golden[a] = d;
        cache_req(0, 1, a, d, rd, lat, ok);
        chk($sformatf("rnd%0d_wack", n), 128'(ok), 1);
      end else begin
        expd = golden.exists(a) ? golden[a] : init_line(a);
        cache_req(1, 0, a, '0, rd, lat, ok);
        chk($sformatf("rnd%0d_rdata", n), rd, expd);
      end
    end
    wait_for("rnd_drained", 0, 300);
    foreach (golden[k])
      chk($sformatf("rnd_mem_%0h", k), memv.exists(k) ? memv[k] : 128'bx, golden[k]);

    // Reset in the middle of a read with two lines still buffered.
    auto_mem = 0;
    cache_req(0, 1, 28'h50, {4{32'h5050}}, rd, lat, ok);
    cache_req(0, 1, 28'h51, {4{32'h5151}}, rd, lat, ok);
    cache_req(0, 1, 28'h52, {4{32'h5252}}, rd, lat, ok);
    fork
      cache_req(1, 0, 28'h60, '0, rd, lat, ok);
      begin
        man_go = 1;
        wait_for("t6_rd_started", 2, 50);
        #2;
        rst_n = 0;
        #1;
        chk("t6_cache_ready", 128'(cache_ready), 0);
        chk("t6_mem_read",    128'(mem_read),    0);
        chk("t6_mem_write",   128'(mem_write),   0);
        chk("t6_mem_addr",    128'(mem_addr),    0);
        chk("t6_mem_wdata",   mem_wdata,         0);
        chk("t6_cache_rdata", cache_rdata,       0);
        chk("t6_wb_empty",    128'(wb_empty),    1);
        repeat (3) @(negedge clk);
      end
    join
    man_go = 0;
    rst_n = 1;
    auto_mem = 1;
    m  = oplog.size();
    wc = wr_cycles;
    repeat (30) @(negedge clk);
    ac = wr_cycles - wc;
    chk("t6_no_mem_write", 128'(ac), 0);
    chk("t6_no_ops", 128'(oplog.size() - m), 0);
    chk("t6_wb_empty_after", 128'(wb_empty), 1);

    chk("never_both_rw", 128'(both_cnt), 0);
    chk("mem_stable", 128'(unstable), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
